score_bcd_display: RTL

Parametrised, sequential binary-to-decimal seven-segment driver for the score path. It accepts a BIN_W-bit unsigned value on a load strobe and converts it iteratively using shift-and-add-3 (double dabble), one bit per clock. It then drives DIGITS registered seven-segment digits. Successor to the combinational score decoder: any width or digit count, a handshake, overflow saturation, and glitch-free output update.

---
 rtl/score_bcd_display.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/score_bcd_display.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) driving
// registered seven-segment digits. Optional macro: LEADING_ZERO_BLANK_EN.
module score_bcd_display #(
  parameter int BIN_W          = 8,
  parameter int DIGITS         = 3,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  load,
  input  logic [BIN_W-1:0]      value,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   hex
);

  function automatic int dec_digits(input int bits);
    longint v;
    int     n;
    v = (longint'(1) << bits) - 1;
    n = 1;
    for (int i = 0; i < 20; i++) begin
      if (v >= 10) begin
        v = v / 10;
        n = n + 1;
      end
    end
    return n;
  endfunction

  function automatic longint pow10(input int n);
    longint r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // Blanking scans from the top digit down; digit 0 always counts as significant.
  function automatic logic [7*DIGITS-1:0] hex_of(input logic [4*DIGITS-1:0] b);
    logic [7*DIGITS-1:0] r;
    logic [6:0]          s;
`ifdef LEADING_ZERO_BLANK_EN
    logic                seen;
    seen = 1'b0;
`endif
    r = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      s = seg_of(b[4*k +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
      seen = seen | (b[4*k +: 4] != 4'd0) | (k == 0);
      if (!seen) s = 7'h00;
`endif
      r[7*k +: 7] = SEG_ACTIVE_LOW ? ~s : s;
    end
    return r;
  endfunction

  localparam int ACC_DIGITS = (dec_digits(BIN_W) > DIGITS) ? dec_digits(BIN_W) : DIGITS;
  localparam int ACC_W      = 4 * ACC_DIGITS;
  localparam int CNT_W      = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [63:0]         MAX_VAL = 64'(pow10(DIGITS) - 1);
  localparam logic [4*DIGITS-1:0] ALL9    = {DIGITS{4'h9}};
  localparam logic [7*DIGITS-1:0] HEX_RST = hex_of({(4*DIGITS){1'b0}});

  typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_t;

  state_t                state_q, state_d;
  logic [BIN_W-1:0]      shift_q, shift_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [CNT_W-1:0]      step_q, step_d;
  logic                  ovf_q, ovf_d;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d;
  logic [7*DIGITS-1:0]   hex_q, hex_d;
  logic                  overflow_q, overflow_d;
  logic                  done_q, done_d;
  logic [ACC_W-1:0]      acc_adj;
  logic [ACC_W+BIN_W-1:0] shifted;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      acc_q      <= '0;
      step_q     <= '0;
      ovf_q      <= 1'b0;
      bcd_q      <= '0;
      hex_q      <= HEX_RST;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      acc_q      <= acc_d;
      step_q     <= step_d;
      ovf_q      <= ovf_d;
      bcd_q      <= bcd_d;
      hex_q      <= hex_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load) state_d = CONVERT;
      CONVERT: if (step_q == CNT_W'(BIN_W - 1)) state_d = UPDATE;
      UPDATE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: add-3 correction on every nibble, then one left shift per step.
  always_comb begin
    shift_d    = shift_q;
    acc_d      = acc_q;
    step_d     = step_q;
    ovf_d      = ovf_q;
    bcd_d      = bcd_q;
    hex_d      = hex_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    acc_adj    = acc_q;
    for (int i = 0; i < ACC_DIGITS; i++) begin
      if (acc_adj[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_adj[4*i +: 4] + 4'd3;
    end
    shifted = {acc_adj, shift_q} << 1;
    case (state_q)
      IDLE: begin
        if (load) begin
          shift_d = value;
          acc_d   = '0;
          step_d  = '0;
          ovf_d   = 64'(value) > MAX_VAL;
        end
      end
      CONVERT: begin
        acc_d   = shifted[ACC_W+BIN_W-1:BIN_W];
        shift_d = shifted[BIN_W-1:0];
        step_d  = step_q + CNT_W'(1);
      end
      UPDATE: begin
        bcd_d      = ovf_q ? ALL9 : acc_q[4*DIGITS-1:0];
        hex_d      = hex_of(bcd_d);
        overflow_d = ovf_q;
        done_d     = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    busy     = (state_q != IDLE);
    done     = done_q;
    overflow = overflow_q;
    bcd      = bcd_q;
    hex      = hex_q;
  end

endmodule
